// File: rtl/ghash_seq_ctrl.sv
// ghash_seq_ctrl: GHASH sequencer around one GF(2^128) multiplier.
//   Computes Y0=0, Yi=(Yi-1 ^ Xi)*H and presents tag=Yn after the last block.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   h_valid, h_key        load hash subkey H (IDLE only)
//   start                 begin a new message (IDLE, H loaded or loading)
//   clear                 synchronous abort back to IDLE, H retained
//   in_valid/in_ready     block stream handshake, in_data = Xi, in_last = final block
//   out_valid/out_ready   tag handshake, out_tag = Yn
//   busy, h_loaded        status
//   blk_cnt               blocks accepted since start, saturating
module ghash_seq_ctrl #(
   parameter int unsigned MUL_STAGES = 1,
   parameter int unsigned CNT_W      = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               h_valid,
   input  logic [127:0]       h_key,
   input  logic               start,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [127:0]       in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [127:0]       out_tag,
   output logic               busy,
   output logic               h_loaded,
   output logic [CNT_W-1:0]   blk_cnt
);

   localparam int unsigned BLK_W = 128;
   localparam int unsigned STG_W = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // GCM-order GF(2^128) multiply: bit 127 is coefficient x^0, reduction by x^128+x^7+x^2+x+1
   function automatic logic [BLK_W-1:0] gf128_mul_reduced(input logic [BLK_W-1:0] x,
                                                          input logic [BLK_W-1:0] y);
      logic [BLK_W-1:0] z;
      logic [BLK_W-1:0] v;
      z = '0;
      v = y;
      for (int i = 0; i < 128; i++) begin
         if (x[127-i]) z = z ^ v;
         if (v[0]) v = (v >> 1) ^ {8'hE1, 120'd0};
         else      v = v >> 1;
      end
      return z;
   endfunction

   state_e             state_q, state_d;
   logic [BLK_W-1:0]   h_q, h_d;
   logic               h_loaded_q, h_loaded_d;
   logic [BLK_W-1:0]   y_q, y_d;
   logic [BLK_W-1:0]   a_q, a_d;
   logic               last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STG_W-1:0]   stg_q, stg_d;
   logic [BLK_W-1:0]   tag_q, tag_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic [BLK_W-1:0]   pipe_q [MUL_STAGES];
   logic [BLK_W-1:0]   prod_c;
   logic [BLK_W-1:0]   mul_res_c;

   // Multiplier operands are registered (a_q, h_q); the product is retimed through pipe_q
   assign prod_c    = gf128_mul_reduced(a_q, h_q);
   assign mul_res_c = pipe_q[MUL_STAGES-1];

   // Product retiming pipeline; free-running, the stage counter picks the valid slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(MUL_STAGES); k++) pipe_q[k] <= '0;
      end else begin
         pipe_q[0] <= prod_c;
         for (int k = 1; k < int'(MUL_STAGES); k++) pipe_q[k] <= pipe_q[k-1];
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         h_q         <= '0;
         h_loaded_q  <= 1'b0;
         y_q         <= '0;
         a_q         <= '0;
         last_q      <= 1'b0;
         cnt_q       <= '0;
         stg_q       <= '0;
         tag_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         h_loaded_q  <= h_loaded_d;
         y_q         <= y_d;
         a_q         <= a_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         stg_q       <= stg_d;
         tag_q       <= tag_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      h_d        = h_q;
      h_loaded_d = h_loaded_q;
      y_d        = y_q;
      a_d        = a_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      stg_d      = stg_q;
      tag_d      = tag_q;

      if (clear) begin
         // Abort wins over every transition; H and the last tag survive
         state_d = S_IDLE;
         y_d     = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (h_valid) begin
                  h_d        = h_key;
                  h_loaded_d = 1'b1;
               end
               if (start && (h_loaded_q || h_valid)) begin
                  y_d     = '0;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (in_valid && in_ready_q) begin
                  a_d     = y_q ^ in_data;
                  last_d  = in_last;
                  cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                  stg_d   = '0;
                  state_d = S_MUL;
               end
            end
            S_MUL: begin
               // pipe_q[MUL_STAGES-1] holds A*H once MUL_STAGES edges have passed since accept
               if (stg_q == STG_W'(MUL_STAGES)) begin
                  y_d = mul_res_c;
                  if (last_q) begin
                     tag_d   = mul_res_c;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_WAIT;
                  end
               end else begin
                  stg_d = stg_q + STG_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      in_ready_d  = (state_d == S_WAIT);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_tag   = tag_q;
   assign busy      = busy_q;
   assign h_loaded  = h_loaded_q;
   assign blk_cnt   = cnt_q;

endmodule
